// File: rtl/sr_cmd_seq.sv
// Command sequencer for an SR flip-flop stage: turns set/reset requests into
// fixed-width s/r pulses, verifies q feedback and keeps saturating counters.
module sr_cmd_seq #(
  parameter int PULSE_W  = 2,
  parameter int VERIFY_W = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_req,
  input  logic             rst_req,
  input  logic             q_fb,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             conflict,
  output logic             fault,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] rst_cnt
);

  localparam int MAX_W = (PULSE_W > VERIFY_W) ? PULSE_W : VERIFY_W;
  localparam int TW    = $clog2(MAX_W + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, VERIFY} state_t;

  state_t        state;
  logic          op;
  logic [TW-1:0] tmr;

  // One shared down-counter times both the drive pulse and the verify window;
  // op is 1 for SET, which is also the q value expected back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op       <= 1'b0;
      tmr      <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      conflict <= 1'b0;
      fault    <= 1'b0;
      set_cnt  <= '0;
      rst_cnt  <= '0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      conflict <= 1'b0;
      case (state)
        IDLE: begin
          if (set_req && !rst_req) begin
            op    <= 1'b1;
            s     <= 1'b1;
            r     <= 1'b0;
            busy  <= 1'b1;
            tmr   <= TW'(PULSE_W - 1);
            state <= DRIVE;
          end else if (rst_req && !set_req) begin
            op    <= 1'b0;
            s     <= 1'b0;
            r     <= 1'b1;
            busy  <= 1'b1;
            tmr   <= TW'(PULSE_W - 1);
            state <= DRIVE;
          end else if (set_req && rst_req) begin
            conflict <= 1'b1;
          end
        end
        DRIVE: begin
          if (tmr == '0) begin
            s     <= 1'b0;
            r     <= 1'b0;
            tmr   <= TW'(VERIFY_W - 1);
            state <= VERIFY;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        VERIFY: begin
          if (q_fb == op) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
            if (op) begin
              if (set_cnt != {CNT_W{1'b1}}) set_cnt <= set_cnt + CNT_W'(1);
            end else begin
              if (rst_cnt != {CNT_W{1'b1}}) rst_cnt <= rst_cnt + CNT_W'(1);
            end
          end else if (tmr == '0) begin
            err   <= 1'b1;
            fault <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        default: begin
          s     <= 1'b0;
          r     <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
